// File: rtl/spi_master_unit.sv
// Single-byte SPI mode-0 master: an apb_ready strobe starts a full-duplex DATA_W-bit transfer.
// Latency: rx_data_valid is high in the cycle after edge 2*SCLK_HALF*DATA_W, counting the accept edge as 0.
// Backpressure: none. apb_ready is accepted only in IDLE or DONE and is ignored while busy.
// Optional feature macro SPI_LSB_FIRST_EN: when defined, TX and RX use LSB-first bit order.
module spi_master_unit #(
    parameter int SCLK_HALF = 1,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              apb_ready,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              SPI_status_RDY_BSYbar,
    output logic              rx_data_valid,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SCLK,
    output logic              SSbar
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     half_cnt_q, half_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sclk_q, sclk_d;
    logic              ssbar_q, ssbar_d;
    logic              mosi_q, mosi_d;
    logic              rxv_q, rxv_d;
    logic              rdy_q, rdy_d;

    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              load_bit;
    logic              next_bit;

    // Bit-order selection: which WDATA bit goes out first and which way the shifters move.
    always_comb begin
`ifdef SPI_LSB_FIRST_EN
        tx_shift = tx_q >> 1;
        rx_shift = {MISO, rx_q[DATA_W-1:1]};
        load_bit = WDATA[0];
        next_bit = tx_q[1];
`else
        tx_shift = tx_q << 1;
        rx_shift = {rx_q[DATA_W-2:0], MISO};
        load_bit = WDATA[DATA_W-1];
        next_bit = tx_q[DATA_W-2];
`endif
    end

    // Next-state and output-register computation; every SPI pin comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        sclk_d     = sclk_q;
        ssbar_d    = ssbar_q;
        mosi_d     = mosi_q;
        rxv_d      = 1'b0;
        rdy_d      = rdy_q;

        unique case (state_q)
            S_XFER: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK: capture MISO.
                        sclk_d = 1'b1;
                        rx_d   = rx_shift;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        // End of the last high phase: release the slave and publish RX.
                        state_d = S_DONE;
                        sclk_d  = 1'b0;
                        ssbar_d = 1'b1;
                        mosi_d  = 1'b0;
                        rdata_d = rx_q;
                        rxv_d   = 1'b1;
                        rdy_d   = 1'b1;
                    end else begin
                        // Falling SCLK: present the next TX bit.
                        sclk_d    = 1'b0;
                        tx_d      = tx_shift;
                        mosi_d    = next_bit;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HW'(1);
                end
            end
            default: begin
                // IDLE and the single DONE cycle both accept a new write.
                state_d = S_IDLE;
                if (apb_ready) begin
                    state_d    = S_XFER;
                    tx_d       = WDATA;
                    rx_d       = '0;
                    mosi_d     = load_bit;
                    ssbar_d    = 1'b0;
                    sclk_d     = 1'b0;
                    rdy_d      = 1'b0;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
        endcase
    end

    // State and output registers with synchronous active-high reset on rst_n.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            sclk_q     <= 1'b0;
            ssbar_q    <= 1'b1;
            mosi_q     <= 1'b0;
            rxv_q      <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            sclk_q     <= sclk_d;
            ssbar_q    <= ssbar_d;
            mosi_q     <= mosi_d;
            rxv_q      <= rxv_d;
            rdy_q      <= rdy_d;
        end
    end

    assign RDATA                 = rdata_q;
    assign SPI_status_RDY_BSYbar = rdy_q;
    assign rx_data_valid         = rxv_q;
    assign MOSI                  = mosi_q;
    assign SCLK                  = sclk_q;
    assign SSbar                 = ssbar_q;

endmodule

// File: tb/tb_spi_master_unit.sv
// Randomized self-checking bench for spi_master_unit with a high-level SPI slave/reference model.
// Two instances: default timing (SCLK_HALF=1) and a slow clock (SCLK_HALF=3).
// Bit order of the model follows SPI_LSB_FIRST_EN exactly as the design does.
module tb_spi_master_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       apb_ready, apb_ready1;
    logic [7:0] wdata, wdata1;
    logic [7:0] rdata, rdata1;
    logic       rdy, rdy1, rxv, rxv1, mosi, mosi1, sclk, sclk1, ssbar, ssbar1;
    logic       miso, miso1;

    spi_master_unit #(.SCLK_HALF(1), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .apb_ready(apb_ready), .WDATA(wdata), .RDATA(rdata),
        .SPI_status_RDY_BSYbar(rdy), .rx_data_valid(rxv), .MOSI(mosi), .MISO(miso),
        .SCLK(sclk), .SSbar(ssbar)
    );

    spi_master_unit #(.SCLK_HALF(3), .DATA_W(8)) dut_slow (
        .clk(clk), .rst_n(rst_n), .apb_ready(apb_ready1), .WDATA(wdata1), .RDATA(rdata1),
        .SPI_status_RDY_BSYbar(rdy1), .rx_data_valid(rxv1), .MOSI(mosi1), .MISO(miso1),
        .SCLK(sclk1), .SSbar(ssbar1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Bit i on the wire (i = 0 is the first bit sent) for a given byte.
    function automatic logic wire_bit(input logic [7:0] b, input int i);
`ifdef SPI_LSB_FIRST_EN
        return b[i];
`else
        return b[7-i];
`endif
    endfunction

    // Wire sequence packed with the first bit in the MSB position.
    function automatic logic [7:0] wire_seq(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = wire_bit(b, i);
        return r;
    endfunction

    // Slave model for the fast instance: a new byte per SSbar fall, next bit after each SCLK fall.
    logic [7:0] slave_q[$];
    logic [7:0] cur_byte = 8'h00;
    int         sidx = 0;
    logic       p_ss = 1'b1, p_sclk = 1'b0;
    always @(posedge clk) begin
        #1;
        if (p_ss === 1'b1 && ssbar === 1'b0) begin
            cur_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
            sidx = 0;
            miso = wire_bit(cur_byte, 0);
        end else if (ssbar === 1'b0 && p_sclk === 1'b1 && sclk === 1'b0) begin
            sidx++;
            if (sidx < 8) miso = wire_bit(cur_byte, sidx);
        end
        p_ss   = ssbar;
        p_sclk = sclk;
    end

    // Observations collected by run0 for the tests to compare.
    logic       mosi_bits[$];
    int         valid_cyc[$];
    logic [7:0] valid_dat[$];
    int         ss_err, rdy_err;
    logic       rs_ss, rs_sclk, rs_mosi, rs_rdy, rs_rxv;
    logic [7:0] rs_rdata;

    function automatic logic [7:0] pack_bits(input int off);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++)
            if (off + k < mosi_bits.size()) r[7-k] = mosi_bits[off+k];
        return r;
    endfunction

    // Drives one transfer on the fast instance and records what the pins do, cycle by cycle.
    // Cycle c is observed after accept edge + c; -1 disables busy write / reset injection.
    task automatic run0(input logic [7:0] tx, input int ncyc, input int busy_cyc,
                        input logic [7:0] busy_dat, input bit b2b, input logic [7:0] b2b_dat,
                        input int rst_cyc);
        logic prev;
        bit   in_win;
        mosi_bits.delete(); valid_cyc.delete(); valid_dat.delete();
        ss_err = 0; rdy_err = 0; prev = 1'b0;
        @(negedge clk);
        apb_ready = 1'b1; wdata = tx;
        @(negedge clk);
        for (int c = 0; c < ncyc; c++) begin
            if (sclk === 1'b1 && prev === 1'b0) mosi_bits.push_back(mosi);
            prev = sclk;
            if (rxv === 1'b1) begin valid_cyc.push_back(c); valid_dat.push_back(rdata); end
            in_win = (c < 16) || (b2b && c >= 17 && c < 33);
            if (rst_cyc >= 0 && c > rst_cyc) in_win = 1'b0;
            if (in_win && ssbar !== 1'b0) ss_err++;
            if (in_win && rdy !== 1'b0) rdy_err++;
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                rs_ss = ssbar; rs_sclk = sclk; rs_mosi = mosi;
                rs_rdy = rdy; rs_rxv = rxv; rs_rdata = rdata;
                rst_n = 1'b0;
            end
            if (c == rst_cyc) rst_n = 1'b1;
            wdata = 8'($urandom);
            if (c == busy_cyc) begin
                apb_ready = 1'b1; wdata = busy_dat;
            end else if (b2b && rxv === 1'b1 && valid_cyc.size() == 1) begin
                apb_ready = 1'b1; wdata = b2b_dat;
            end else begin
                apb_ready = 1'b0;
            end
            @(negedge clk);
        end
        apb_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; apb_ready = 1'b0; apb_ready1 = 1'b0; wdata = 8'h00; wdata1 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ssbar !== 1'b1) begin n_fail++; $display("FAIL reset_ssbar got=%b exp=1", ssbar); end
        n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
        n_tests++; if (rxv !== 1'b0) begin n_fail++; $display("FAIL reset_rxv got=%b exp=0", rxv); end
        n_tests++; if (ssbar1 !== 1'b1 || sclk1 !== 1'b0) begin n_fail++; $display("FAIL reset_slow ss=%b sclk=%b exp=1/0", ssbar1, sclk1); end
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        slave_q.push_back(8'h5A);
        run0(8'hAA, 24, -1, 8'h00, 1'b0, 8'h00, -1);
        n_tests++; if (mosi_bits.size() != 8) begin n_fail++; $display("FAIL basic_pulses got=%0d exp=8", mosi_bits.size()); end
        n_tests++; if (pack_bits(0) !== wire_seq(8'hAA)) begin n_fail++; $display("FAIL basic_mosi got=%h exp=%h", pack_bits(0), wire_seq(8'hAA)); end
        n_tests++; if (valid_cyc.size() != 1 || valid_cyc[0] != 16) begin n_fail++; $display("FAIL basic_valid n=%0d first=%0d exp=1@16", valid_cyc.size(), (valid_cyc.size() > 0) ? valid_cyc[0] : -1); end
        n_tests++; if (valid_dat.size() < 1 || valid_dat[0] !== 8'h5A) begin n_fail++; $display("FAIL basic_rdata got=%h exp=5a", (valid_dat.size() > 0) ? valid_dat[0] : 8'hxx); end
        n_tests++; if (ss_err != 0) begin n_fail++; $display("FAIL basic_ssbar high_cycles=%0d exp=0", ss_err); end
        n_tests++; if (rdata !== 8'h5A || rdy !== 1'b1) begin n_fail++; $display("FAIL basic_hold rdata=%h rdy=%b exp=5a/1", rdata, rdy); end
    endtask

    task automatic test_busy_write();
        slave_q.push_back(8'h81);
        run0(8'hAA, 40, 5, 8'h33, 1'b0, 8'h00, -1);
        n_tests++; if (pack_bits(0) !== wire_seq(8'hAA) || mosi_bits.size() != 8) begin n_fail++; $display("FAIL busy_mosi got=%h n=%0d exp=%h n=8", pack_bits(0), mosi_bits.size(), wire_seq(8'hAA)); end
        n_tests++; if (valid_cyc.size() != 1) begin n_fail++; $display("FAIL busy_nvalid got=%0d exp=1", valid_cyc.size()); end
        n_tests++; if (rdy_err != 0) begin n_fail++; $display("FAIL busy_rdy ready_cycles=%0d exp=0", rdy_err); end
        n_tests++; if (rdata !== 8'h81) begin n_fail++; $display("FAIL busy_rdata got=%h exp=81", rdata); end
    endtask

    task automatic test_back_to_back();
        slave_q.push_back(8'h96);
        slave_q.push_back(8'h3C);
        run0(8'h5A, 44, -1, 8'h00, 1'b1, 8'hC3, -1);
        n_tests++; if (valid_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_nvalid got=%0d exp=2", valid_cyc.size()); end
        n_tests++; if (valid_cyc.size() == 2 && valid_cyc[1] - valid_cyc[0] != 17) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=17", valid_cyc[1] - valid_cyc[0]); end
        n_tests++; if (pack_bits(8) !== wire_seq(8'hC3)) begin n_fail++; $display("FAIL b2b_mosi got=%h exp=%h", pack_bits(8), wire_seq(8'hC3)); end
        n_tests++; if (valid_dat.size() != 2 || valid_dat[0] !== 8'h96 || valid_dat[1] !== 8'h3C) begin n_fail++; $display("FAIL b2b_rdata n=%0d exp=96,3c", valid_dat.size()); end
        n_tests++; if (ss_err != 0) begin n_fail++; $display("FAIL b2b_ssbar high_cycles=%0d exp=0", ss_err); end
    endtask

    task automatic test_random();
        logic [7:0] tx, sb;
        for (int it = 0; it < 5; it++) begin
            tx = 8'($urandom);
            sb = 8'($urandom);
            slave_q.push_back(sb);
            run0(tx, 22, -1, 8'h00, 1'b0, 8'h00, -1);
            n_tests++; if (pack_bits(0) !== wire_seq(tx) || mosi_bits.size() != 8) begin n_fail++; $display("FAIL rand_mosi tx=%h got=%h exp=%h", tx, pack_bits(0), wire_seq(tx)); end
            n_tests++; if (valid_cyc.size() != 1 || valid_cyc[0] != 16 || valid_dat[0] !== sb) begin n_fail++; $display("FAIL rand_rx n=%0d exp=1@16 data=%h", valid_cyc.size(), sb); end
        end
    endtask

    task automatic test_mid_reset();
        slave_q.push_back(8'hE7);
        run0(8'hA5, 24, -1, 8'h00, 1'b0, 8'h00, 7);
        n_tests++; if (rs_ss !== 1'b1 || rs_sclk !== 1'b0 || rs_mosi !== 1'b0) begin n_fail++; $display("FAIL mrst_pins ss=%b sclk=%b mosi=%b exp=1/0/0", rs_ss, rs_sclk, rs_mosi); end
        n_tests++; if (rs_rdy !== 1'b1 || rs_rxv !== 1'b0 || rs_rdata !== 8'h00) begin n_fail++; $display("FAIL mrst_status rdy=%b rxv=%b rdata=%h exp=1/0/00", rs_rdy, rs_rxv, rs_rdata); end
        n_tests++; if (valid_cyc.size() != 0) begin n_fail++; $display("FAIL mrst_novalid got=%0d exp=0", valid_cyc.size()); end
        slave_q.push_back(8'hB4);
        run0(8'h0F, 24, -1, 8'h00, 1'b0, 8'h00, -1);
        n_tests++; if (pack_bits(0) !== wire_seq(8'h0F)) begin n_fail++; $display("FAIL mrst_after_mosi got=%h exp=%h", pack_bits(0), wire_seq(8'h0F)); end
        n_tests++; if (valid_cyc.size() != 1 || valid_cyc[0] != 16 || valid_dat[0] !== 8'hB4) begin n_fail++; $display("FAIL mrst_after_rx n=%0d exp=1@16 b4", valid_cyc.size()); end
    endtask

    task automatic test_slow_clock();
        logic prev_s, first_bit, got_first;
        int   run, nruns, bad, vcyc;
        @(negedge clk);
        apb_ready1 = 1'b1; wdata1 = 8'h01;
        @(negedge clk);
        apb_ready1 = 1'b0;
        prev_s = sclk1; run = 1; nruns = 0; bad = 0; vcyc = -1; got_first = 1'b0; first_bit = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (c > 0 && vcyc < 0) begin
                if (sclk1 !== prev_s) begin
                    nruns++;
                    if (run != 3) bad++;
                    run = 1;
                end else begin
                    run++;
                end
            end
            if (!got_first && sclk1 === 1'b1) begin first_bit = mosi1; got_first = 1'b1; end
            if (rxv1 === 1'b1 && vcyc < 0) vcyc = c;
            prev_s = sclk1;
            @(negedge clk);
        end
        n_tests++; if (nruns != 16 || bad != 0) begin n_fail++; $display("FAIL slow_phases runs=%0d bad=%0d exp=16/0", nruns, bad); end
        n_tests++; if (first_bit !== wire_bit(8'h01, 0)) begin n_fail++; $display("FAIL slow_first_bit got=%b exp=%b", first_bit, wire_bit(8'h01, 0)); end
        n_tests++; if (vcyc != 48) begin n_fail++; $display("FAIL slow_latency got=%0d exp=48", vcyc); end
        n_tests++; if (rdata1 !== 8'hFF) begin n_fail++; $display("FAIL slow_rdata got=%h exp=ff", rdata1); end
    endtask

    initial begin
        miso = 1'b0;
        miso1 = 1'b1;
        test_reset();
        test_basic();
        test_busy_write();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_slow_clock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
